// File: rtl/vid_rx_to_st.sv
// vid_rx_to_st: clocked-video (RGB888 + HS/VS/DE) receiver to a
// ready/valid pixel stream framed with sop/eop.
// Ports: clk, reset (async, active-high); vid_data/hs/vs/de video in;
// enable (frame-boundary capture gate); clear_status (clears sticky
// flags); st_data/st_valid/st_ready/st_sop/st_eop stream out;
// overflow, line_err sticky flags; frame_count completed frames.
// Macro VID_RX_MEASURE_EN adds meas_width/meas_height outputs.
module vid_rx_to_st #(
  parameter int H_ACTIVE        = 800,
  parameter int V_ACTIVE        = 480,
  parameter int FIFO_DEPTH      = 512,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] vid_data,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic        enable,
  input  logic        clear_status,
  output logic [23:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sop,
  output logic        st_eop,
  output logic        overflow,
  output logic        line_err,
  output logic [15:0] frame_count
`ifdef VID_RX_MEASURE_EN
  ,
  output logic [11:0] meas_width,
  output logic [11:0] meas_height
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0] H_C = 12'(H_ACTIVE);
  localparam logic [11:0] V_C = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    SEEK, ARMED, ACTIVE, DROP
  } state_t;

  state_t      state_q;
  logic [23:0] data_q;
  logic        de_q, de_p_q;
  logic        vs_q, vs_p_q, hs_q;
  logic [23:0] hold_q;
  logic        hold_sop_q, hold_vld_q;
  logic [11:0] pix_q, lines_q, lastw_q;
  logic [15:0] fcnt_q;
  logic        ovf_q, lerr_q;

  logic [25:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  logic        vs_lead, de_fall;
  logic        full, empty, pop;
  logic        push_req, push, ovf_ev, lerr_ev;
  logic [25:0] push_word, rd_word;
  logic [11:0] lines_d, width_d;
  logic        unused_hs;

  assign unused_hs = hs_q;
  assign vs_lead = vs_q & ~vs_p_q;
  assign de_fall = de_p_q & ~de_q;
  assign full    = (cnt_q == FULL_C);
  assign empty   = (cnt_q == '0);
  assign pop     = ~empty & st_ready;

  // Line count including a line whose DE falls on this cycle
  assign lines_d = (de_fall && lines_q != 12'hFFF)
                 ? lines_q + 12'd1 : lines_q;
  assign width_d = de_fall ? pix_q : lastw_q;

  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    lerr_ev   = 1'b0;
    if (state_q == ACTIVE) begin
      if (de_fall && pix_q != H_C) lerr_ev = 1'b1;
      if (vs_lead) begin
        // DE during vs_lead is a blanking violation
        if (de_q || lines_d != V_C) lerr_ev = 1'b1;
        push_req  = hold_vld_q;
        push_word = {hold_q, hold_sop_q, 1'b1};
      end else if (de_q) begin
        push_req  = hold_vld_q;
        push_word = {hold_q, hold_sop_q, 1'b0};
      end
    end
  end

  // Full is judged before any same-cycle pop
  assign push   = push_req & ~full;
  assign ovf_ev = push_req & full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_word;
  end

  assign rd_word  = mem_q[rd_q];
  assign st_valid = ~empty;
  assign st_data  = st_valid ? rd_word[25:2] : '0;
  assign st_sop   = st_valid & rd_word[1];
  assign st_eop   = st_valid & rd_word[0];

`ifdef VID_RX_MEASURE_EN
  logic [11:0] meas_w_q, meas_h_q;
  assign meas_width  = meas_w_q;
  assign meas_height = meas_h_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEEK;
      data_q     <= '0;
      de_q       <= 1'b0;
      de_p_q     <= 1'b0;
      vs_q       <= 1'b0;
      vs_p_q     <= 1'b0;
      hs_q       <= 1'b0;
      hold_q     <= '0;
      hold_sop_q <= 1'b0;
      hold_vld_q <= 1'b0;
      pix_q      <= '0;
      lines_q    <= '0;
      lastw_q    <= '0;
      fcnt_q     <= '0;
      ovf_q      <= 1'b0;
      lerr_q     <= 1'b0;
`ifdef VID_RX_MEASURE_EN
      meas_w_q   <= '0;
      meas_h_q   <= '0;
`endif
    end else begin
      data_q <= vid_data;
      de_q   <= vid_de;
      hs_q   <= vid_hs ^ SYNC_ACTIVE_LOW;
      vs_q   <= vid_vs ^ SYNC_ACTIVE_LOW;
      vs_p_q <= vs_q;
      de_p_q <= de_q;
      ovf_q  <= (ovf_q & ~clear_status) | ovf_ev;
      lerr_q <= (lerr_q & ~clear_status) | lerr_ev;
      case (state_q)
        SEEK: begin
          if (vs_lead && enable) state_q <= ARMED;
        end
        ARMED: begin
          if (vs_lead) begin
            if (!enable) state_q <= SEEK;
          end else if (de_q) begin
            hold_q     <= data_q;
            hold_sop_q <= 1'b1;
            hold_vld_q <= 1'b1;
            pix_q      <= 12'd1;
            lines_q    <= '0;
            lastw_q    <= '0;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (de_fall) begin
            pix_q   <= '0;
            lines_q <= lines_d;
            lastw_q <= pix_q;
          end else if (de_q && !vs_lead
                       && pix_q != 12'hFFF) begin
            pix_q <= pix_q + 12'd1;
          end
          if (vs_lead) begin
            hold_vld_q <= 1'b0;
            state_q    <= enable ? ARMED : SEEK;
            if (push) fcnt_q <= fcnt_q + 16'd1;
`ifdef VID_RX_MEASURE_EN
            meas_w_q <= width_d;
            meas_h_q <= lines_d;
`endif
          end else if (ovf_ev) begin
            hold_vld_q <= 1'b0;
            state_q    <= DROP;
          end else if (de_q) begin
            hold_q     <= data_q;
            hold_sop_q <= 1'b0;
          end
        end
        DROP: begin
          if (vs_lead) state_q <= enable ? ARMED : SEEK;
        end
        default: state_q <= SEEK;
      endcase
    end
  end

  assign overflow    = ovf_q;
  assign line_err    = lerr_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vid_rx_to_st.sv
// tb_vid_rx_to_st: directed self-checking bench for vid_rx_to_st,
// using a reduced 16x8 raster and a 16-entry FIFO.
module tb_vid_rx_to_st;

  localparam int HA = 16;
  localparam int VA = 8;
  localparam int FD = 16;
  localparam int NP = HA * VA;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] vid_data;
  logic        vid_hs, vid_vs, vid_de;
  logic        enable, clear_status;
  logic [23:0] st_data;
  logic        st_valid, st_ready, st_sop, st_eop;
  logic        overflow, line_err;
  logic [15:0] frame_count;
`ifdef VID_RX_MEASURE_EN
  logic [11:0] meas_width, meas_height;
`endif

  always #5 clk = ~clk;

  vid_rx_to_st #(
    .H_ACTIVE(HA), .V_ACTIVE(VA),
    .FIFO_DEPTH(FD), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_data(vid_data), .vid_hs(vid_hs),
    .vid_vs(vid_vs), .vid_de(vid_de),
    .enable(enable), .clear_status(clear_status),
    .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop),
    .st_eop(st_eop), .overflow(overflow),
    .line_err(line_err), .frame_count(frame_count)
`ifdef VID_RX_MEASURE_EN
    ,
    .meas_width(meas_width),
    .meas_height(meas_height)
`endif
  );

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
  } xfer_t;

  xfer_t       xq[$];
  logic [23:0] eq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_fc = 0;

  always @(negedge clk)
    if (!reset && st_valid && st_ready)
      xq.push_back({st_data, st_sop, st_eop});

  function automatic logic [23:0] pix(int f, int l, int x);
    return {f[7:0], l[7:0], x[7:0]};
  endfunction

  function automatic void build_exp(int f, int sl, int slen);
    eq.delete();
    for (int l = 0; l < VA; l++)
      for (int x = 0; x < ((l == sl) ? slen : HA); x++)
        eq.push_back(pix(f, l, x));
  endfunction

  // Mismatches of xq[base..] against eq (data, sop, eop)
  function automatic int frame_bad(int base, bit want_eop);
    int b = 0;
    if (xq.size() < base + eq.size()) return -1;
    foreach (eq[i]) begin
      xfer_t t;
      t = xq[base + i];
      if (t.d !== eq[i] || t.s !== (i == 0)
          || t.e !== (want_eop && i == eq.size() - 1))
        b++;
    end
    return b;
  endfunction

  task automatic blank();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vid_de = 1'b0;
      vid_data = '0;
      vid_hs = (i < 2) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic send_line(input int f, input int l,
                           input int len);
    for (int x = 0; x < len; x++) begin
      @(posedge clk); #1;
      vid_de = 1'b1;
      vid_data = pix(f, l, x);
    end
    blank();
  endtask

  task automatic vsync();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vid_de = 1'b0;
      vid_vs = (i < 3) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic send_frame(input int f, input int sl,
                            input int slen);
    for (int l = 0; l < VA; l++)
      send_line(f, l, (l == sl) ? slen : HA);
    vsync();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (st_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", st_valid);
    end
    n_cmp++;
    if (st_data !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", st_data);
    end
    n_cmp++;
    if ({st_sop, st_eop} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_sop_eop: got %b want 00",
               {st_sop, st_eop});
    end
    n_cmp++;
    if ({overflow, line_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00",
               {overflow, line_err});
    end
    n_cmp++;
    if (frame_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_fc: got %0d want 0", frame_count);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (st_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_valid: got %b want 0", st_valid);
    end
  endtask

  task automatic test_latency();
    int b;
    xq.delete();
    vsync();
    for (int x = 0; x < HA; x++) begin
      @(posedge clk); #1;
      vid_de = 1'b1;
      vid_data = (x == 0) ? 24'h123456 : pix(1, 0, x);
      if (x == 2) begin
        n_cmp++;
        if (st_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL lat_c2_valid: got %b want 0",
                   st_valid);
        end
      end
      if (x == 3) begin
        n_cmp++;
        if ({st_valid, st_sop} !== 2'b11) begin
          n_bad++;
          $display("FAIL lat_c3_vs: got %b want 11",
                   {st_valid, st_sop});
        end
        n_cmp++;
        if (st_data !== 24'h123456) begin
          n_bad++;
          $display("FAIL lat_c3_data: got %h want 123456",
                   st_data);
        end
      end
    end
    blank();
    for (int l = 1; l < VA; l++) send_line(1, l, HA);
    vsync();
    exp_fc++;
    build_exp(1, -1, 0);
    eq[0] = 24'h123456;
    n_cmp++;
    if (xq.size() !== NP) begin
      n_bad++;
      $display("FAIL lat_count: got %0d want %0d",
               xq.size(), NP);
    end
    b = frame_bad(0, 1'b1);
    n_cmp++;
    if (b !== 0) begin
      n_bad++;
      $display("FAIL lat_frame: got %0d bad want 0", b);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL lat_fc: got %0d want %0d",
               frame_count, exp_fc);
    end
    n_cmp++;
    if ({overflow, line_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL lat_flags: got %b want 00",
               {overflow, line_err});
    end
  endtask

  task automatic test_frames();
    int b;
    xq.delete();
    for (int f = 2; f < 4; f++) begin
      send_frame(f, -1, 0);
      exp_fc++;
      build_exp(f, -1, 0);
      b = frame_bad((f - 2) * NP, 1'b1);
      n_cmp++;
      if (b !== 0) begin
        n_bad++;
        $display("FAIL frames_%0d: got %0d bad want 0", f, b);
      end
      n_cmp++;
      if (frame_count !== 16'(exp_fc)) begin
        n_bad++;
        $display("FAIL frames_fc_%0d: got %0d want %0d",
                 f, frame_count, exp_fc);
      end
    end
    n_cmp++;
    if (xq.size() !== 2 * NP) begin
      n_bad++;
      $display("FAIL frames_count: got %0d want %0d",
               xq.size(), 2 * NP);
    end
    n_cmp++;
    if ({overflow, line_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL frames_flags: got %b want 00",
               {overflow, line_err});
    end
  endtask

  task automatic test_overflow();
    int b;
    xq.delete();
    st_ready = 1'b0;
    send_frame(4, -1, 0);
    n_cmp++;
    if (xq.size() !== 0) begin
      n_bad++;
      $display("FAIL ovf_stall: got %0d xfers want 0",
               xq.size());
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag: got %b want 1", overflow);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL ovf_fc: got %0d want %0d",
               frame_count, exp_fc);
    end
    n_cmp++;
    if ({st_valid, st_sop, st_data}
        !== {2'b11, pix(4, 0, 0)}) begin
      n_bad++;
      $display("FAIL ovf_hold: got %b%b %h want 11 %h",
               st_valid, st_sop, st_data, pix(4, 0, 0));
    end
    st_ready = 1'b1;
    repeat (FD + 4) @(posedge clk);
    #1;
    n_cmp++;
    if (xq.size() !== FD) begin
      n_bad++;
      $display("FAIL ovf_drain: got %0d want %0d",
               xq.size(), FD);
    end
    eq.delete();
    for (int x = 0; x < FD; x++) eq.push_back(pix(4, 0, x));
    b = frame_bad(0, 1'b0);
    n_cmp++;
    if (b !== 0) begin
      n_bad++;
      $display("FAIL ovf_trunc: got %0d bad want 0", b);
    end
    send_frame(5, -1, 0);
    exp_fc++;
    build_exp(5, -1, 0);
    b = frame_bad(FD, 1'b1);
    n_cmp++;
    if (b !== 0) begin
      n_bad++;
      $display("FAIL ovf_resync: got %0d bad want 0", b);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL ovf_fc2: got %0d want %0d",
               frame_count, exp_fc);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
  endtask

  task automatic test_line_err();
    int b;
    pulse_clear();
    n_cmp++;
    if ({overflow, line_err} !== 2'b00) begin
      n_bad++;
      $display("FAIL clr_ovf: got %b want 00",
               {overflow, line_err});
    end
    xq.delete();
    for (int l = 0; l < VA; l++) begin
      send_line(6, l, (l == 5) ? HA - 1 : HA);
      if (l == 4) begin
        n_cmp++;
        if (line_err !== 1'b0) begin
          n_bad++;
          $display("FAIL lerr_pre: got %b want 0", line_err);
        end
      end
      if (l == 5) begin
        n_cmp++;
        if (line_err !== 1'b1) begin
          n_bad++;
          $display("FAIL lerr_short: got %b want 1", line_err);
        end
      end
    end
    vsync();
    exp_fc++;
    build_exp(6, 5, HA - 1);
    n_cmp++;
    if (xq.size() !== NP - 1) begin
      n_bad++;
      $display("FAIL lerr_count: got %0d want %0d",
               xq.size(), NP - 1);
    end
    b = frame_bad(0, 1'b1);
    n_cmp++;
    if (b !== 0) begin
      n_bad++;
      $display("FAIL lerr_frame: got %0d bad want 0", b);
    end
    pulse_clear();
    n_cmp++;
    if (line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL lerr_clear: got %b want 0", line_err);
    end
    xq.delete();
    send_frame(7, -1, 0);
    exp_fc++;
    n_cmp++;
    if ({line_err, 16'(xq.size()), frame_count}
        !== {1'b0, 16'(NP), 16'(exp_fc)}) begin
      n_bad++;
      $display("FAIL lerr_clean: got %b %0d %0d want 0 %0d %0d",
               line_err, xq.size(), frame_count, NP, exp_fc);
    end
  endtask

  task automatic test_enable();
    int b;
    xq.delete();
    for (int l = 0; l < 4; l++) send_line(8, l, HA);
    enable = 1'b0;
    for (int l = 4; l < VA; l++) send_line(8, l, HA);
    vsync();
    exp_fc++;
    build_exp(8, -1, 0);
    b = frame_bad(0, 1'b1);
    n_cmp++;
    if (b !== 0 || xq.size() !== NP) begin
      n_bad++;
      $display("FAIL en_finish: got %0d bad %0d xfers want 0 %0d",
               b, xq.size(), NP);
    end
    send_frame(9, -1, 0);
    n_cmp++;
    if (xq.size() !== NP) begin
      n_bad++;
      $display("FAIL en_off: got %0d xfers want %0d",
               xq.size(), NP);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL en_off_fc: got %0d want %0d",
               frame_count, exp_fc);
    end
    enable = 1'b1;
    vsync();
    send_frame(10, -1, 0);
    exp_fc++;
    build_exp(10, -1, 0);
    b = frame_bad(NP, 1'b1);
    n_cmp++;
    if (b !== 0) begin
      n_bad++;
      $display("FAIL en_resume: got %0d bad want 0", b);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL en_fc: got %0d want %0d",
               frame_count, exp_fc);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    for (int l = 0; l < 4; l++) send_line(11, l, HA);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    exp_fc = 0;
    n_cmp++;
    if ({st_valid, st_sop, st_eop, st_data} !== 27'h0) begin
      n_bad++;
      $display("FAIL rst_mid_st: got %b%b%b %h want all 0",
               st_valid, st_sop, st_eop, st_data);
    end
    n_cmp++;
    if ({overflow, line_err, frame_count} !== 18'h0) begin
      n_bad++;
      $display("FAIL rst_mid_status: got %b%b %0d want 0",
               overflow, line_err, frame_count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    xq.delete();
    for (int l = 4; l < VA; l++) send_line(11, l, HA);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (xq.size() !== 0 || st_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_quiet: got %0d xfers want 0",
               xq.size());
    end
    vsync();
    send_frame(12, -1, 0);
    exp_fc++;
    build_exp(12, -1, 0);
    b = frame_bad(0, 1'b1);
    n_cmp++;
    if (b !== 0 || xq.size() !== NP) begin
      n_bad++;
      $display("FAIL rst_resume: got %0d bad %0d xfers want 0 %0d",
               b, xq.size(), NP);
    end
    n_cmp++;
    if (frame_count !== 16'(exp_fc)) begin
      n_bad++;
      $display("FAIL rst_fc: got %0d want %0d",
               frame_count, exp_fc);
    end
  endtask

  initial begin
    reset = 1'b1;
    vid_data = '0;
    vid_hs = 1'b1;
    vid_vs = 1'b1;
    vid_de = 1'b0;
    enable = 1'b1;
    clear_status = 1'b0;
    st_ready = 1'b1;
    test_reset();
    test_latency();
    test_frames();
    test_overflow();
    test_line_err();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vid_rx_to_st.md
Name: vid_rx_to_st

Overview:
- Receiver for the clocked-video interface that drives the MTL panel and VGA DAC: parallel RGB888 with HS, VS and DE.
- Converts incoming video back into a ready/valid pixel stream with sop/eop framing, for capture into SDRAM frame buffers, for loopback test of the timing generator, or for an external video source on GPIO.
- Single clock domain: the pixel clock is the block clock.

Parameters:
- H_ACTIVE, 800, expected active pixels per line.
- V_ACTIVE, 480, expected active lines per frame.
- FIFO_DEPTH, 512, output FIFO entries; must be a power of 2, minimum 4.
- SYNC_ACTIVE_LOW, 1, 1 = vid_hs/vid_vs asserted low (panel-pin polarity); 0 = asserted high.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- vid_data  in  24  pixel, {R[7:0],G[7:0],B[7:0]}.
- vid_hs  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW.
- vid_vs  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW.
- vid_de  in  1  data enable, active-high.
- enable  in  1  capture enable; sampled only at frame boundaries.
- clear_status  in  1  one-cycle pulse; clears overflow and line_err.
- st_data  out  24  output pixel.
- st_valid  out  1  st_data/st_sop/st_eop valid.
- st_ready  in  1  downstream accept.
- st_sop  out  1  first pixel of frame.
- st_eop  out  1  last pixel of frame.
- overflow  out  1  sticky; FIFO full on a write attempt.
- line_err  out  1  sticky; line length or line count mismatch.
- frame_count  out  16  completed frames emitted with eop; wraps 0xFFFF->0.

Behaviour:
- Reset, asynchronous: FIFO empty, state SEEK, all outputs 0, hold register invalid.
- Input stage: vid_* registered once; syncs normalised to active-high. vs_lead = rising edge of normalised VS in the registered domain.
- Hold register: one-pixel delay so eop can be attached retroactively at frame end. A pixel is written to the FIFO when the next DE pixel arrives (eop=0) or at vs_lead (eop=1).
- Latency, continuous DE, FIFO empty, st_ready=1: pixel 0 on pins in cycle 0 appears on st_data with st_valid=1, st_sop=1 in cycle 3.
- SEEK: ignore all input. On vs_lead with enable=1 -> ARMED.
- ARMED: on first registered DE pixel, load hold with sop=1, clear per-frame counters, -> ACTIVE. A vs_lead with no pixels emits nothing and leaves frame_count unchanged. If enable=0 at vs_lead -> SEEK.
- ACTIVE, each DE pixel: push hold (if valid), load new pixel.
- ACTIVE, vs_lead: push hold with eop=1, frame_count+1, check line count.
  - -> ARMED if enable=1, else SEEK.
  - Deasserting enable mid-frame always completes the current frame.
- ACTIVE, push attempt while FIFO full: pixel discarded, overflow=1, hold invalidated, -> DROP. The truncated frame has no eop; downstream resynchronises on the next sop.
- DROP: ignore pixels. vs_lead -> ARMED (enable=1) or SEEK; frame_count unchanged.
- Line check (ACTIVE only):
  - Count DE pixels per line, 12 bits, saturating.
  - At DE falling edge, count != H_ACTIVE -> line_err=1.
  - Lines counted on DE falling edge; at vs_lead, lines != V_ACTIVE -> line_err=1.
  - A frame with errors is still emitted with sop/eop.
- Simultaneous vs_lead and registered DE in the same cycle: the pixel is treated as a blanking violation, discarded, line_err=1. Frame end is processed normally.
- clear_status coincident with a new error event: the error wins (flag stays 1).
- FIFO is show-ahead. st_valid = !empty. A transfer occurs when st_valid & st_ready. st_data/sop/eop are held stable while st_valid & !st_ready. A push and a pop in the same cycle are both allowed when the FIFO is full before the pop? No: full is evaluated before the pop, so that push counts as overflow.

Optional Feature:
- Macro: VID_RX_MEASURE_EN.
- Defined: adds outputs meas_width[11:0] and meas_height[11:0], both reset to 0.
  - Updated at each vs_lead ending an ACTIVE frame.
  - Values are the last line's pixel count and the frame's line count (saturating at 4095), even when they match the parameters.
- Undefined: ports and counters absent; line_err behaviour unchanged.

Test Plan:
- Continuous 800x480 frames, st_ready=1 -> exactly 384000 transfers per frame; sop on the first, eop on the 384000th; frame_count increments by 1 per frame; line_err=0, overflow=0.
- Pixel 0 data 0x123456 on pins at cycle 0, DE continuous -> st_valid=1, st_data=0x123456, st_sop=1 first seen at cycle 3.
- st_ready=0 for a whole frame, FIFO_DEPTH=512 -> 512 entries held; overflow=1; frame_count unchanged; after st_ready=1 and the next full frame, the next transfer has sop=1 and frame_count rises by 1.
- Line 10 with 799 DE pixels -> line_err=1 at that line's DE fall; the frame still ends with eop; clear_status clears line_err; the next clean frame keeps it 0.
- enable dropped mid-frame -> current frame completes with eop, later frames produce no output; re-enable -> output resumes at the next frame with sop.
- reset asserted mid-frame -> all outputs 0 immediately; after release, no output until vs_lead followed by DE; the first transfer has sop=1.
